// File: rtl/eth_pkg.sv
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared constants, state encoding and byte-wide CRC-32 step
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam int          ETH_MIN_FRAME   = 60;
    localparam int          ETH_MAX_FRAME   = 1514;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_PAD  = 3'd2,
        ST_FCS  = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    // Reflected CRC-32, one byte consumed LSB first.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/eth_crc32.sv
// ============================================================================
//  Module      : eth_crc32
//  Description : Byte-wide CRC-32 register; init may coincide with the first byte
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_crc32
    import eth_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        init,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] r_crc;
    logic [31:0] w_base;

    // A byte arriving together with init is folded into a fresh CRC.
    assign w_base = init ? CRC32_INIT : r_crc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_crc <= CRC32_INIT;
        end else if (enable) begin
            r_crc <= crc32_next(w_base, data);
        end else if (init) begin
            r_crc <= CRC32_INIT;
        end
    end

    assign crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/eth_tx_fcs_append.sv
// ============================================================================
//  Module      : eth_tx_fcs_append
//  Description : Pads a raw MAC frame to the minimum length and appends the FCS
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_tx_fcs_append
    import eth_pkg::*;
#(
    parameter int MIN_BYTES = ETH_MIN_FRAME,
    parameter int MAX_BYTES = ETH_MAX_FRAME
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       ready,
    input  logic       phy_active,
    output logic [7:0] out_data,
    output logic       out_enable,
    output logic       overrun,
    output logic       too_long
);

    localparam logic [10:0] c_min = 11'(MIN_BYTES);
    localparam logic [10:0] c_max = 11'(MAX_BYTES);

    state_t      r_state, w_state_nxt;
    logic [10:0] r_count, w_count_nxt, w_count_inc;
    logic [1:0]  r_fcs_idx, w_fcs_idx_nxt;
    logic        r_in_valid_prev;
    logic        r_too_long_seen, w_too_long_seen_nxt;
    logic        w_rise;
    logic [7:0]  w_byte;
    logic        w_en, w_crc_en, w_crc_init, w_overrun, w_too_long;
    logic [31:0] w_crc, w_fcs;
    logic [7:0]  w_fcs_byte;

    eth_crc32 u_crc (
        .clock  (clock),
        .reset  (reset),
        .init   (w_crc_init),
        .enable (w_crc_en),
        .data   (w_byte),
        .crc    (w_crc)
    );

    assign ready       = (r_state == ST_IDLE) & ~phy_active & ~out_enable;
    assign w_rise      = in_valid & ~r_in_valid_prev;
    assign w_count_inc = (r_count == 11'h7FF) ? r_count : r_count + 11'd1;
    assign w_fcs       = ~w_crc;
    assign w_fcs_byte  = w_fcs[{r_fcs_idx, 3'b000} +: 8];

    always_comb begin
        w_state_nxt         = r_state;
        w_count_nxt         = r_count;
        w_fcs_idx_nxt       = r_fcs_idx;
        w_too_long_seen_nxt = r_too_long_seen;
        w_byte              = 8'h00;
        w_en                = 1'b0;
        w_crc_en            = 1'b0;
        w_crc_init          = 1'b0;
        w_overrun           = 1'b0;
        w_too_long          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only a genuine rising edge starts a frame; a stream already in
                // flight (e.g. after reset) is swallowed by DROP without overrun.
                if (w_rise && ready) begin
                    w_byte              = in_data;
                    w_en                = 1'b1;
                    w_crc_en            = 1'b1;
                    w_crc_init          = 1'b1;
                    w_count_nxt         = 11'd1;
                    w_fcs_idx_nxt       = 2'd0;
                    w_too_long_seen_nxt = 1'b0;
                    w_state_nxt         = ST_DATA;
                end else if (in_valid) begin
                    w_overrun   = w_rise;
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DATA: begin
                if (in_valid) begin
                    if (r_count < c_max) begin
                        w_byte      = in_data;
                        w_en        = 1'b1;
                        w_crc_en    = 1'b1;
                        w_count_nxt = w_count_inc;
                    end else if (!r_too_long_seen) begin
                        w_too_long          = 1'b1;
                        w_too_long_seen_nxt = 1'b1;
                    end
                end else if (r_count < c_min) begin
                    w_en          = 1'b1;
                    w_crc_en      = 1'b1;
                    w_count_nxt   = w_count_inc;
                    w_fcs_idx_nxt = 2'd0;
                    w_state_nxt   = (w_count_inc >= c_min) ? ST_FCS : ST_PAD;
                end else begin
                    // Fall straight into the FCS with no idle cycle.
                    w_byte        = w_fcs[7:0];
                    w_en          = 1'b1;
                    w_fcs_idx_nxt = 2'd1;
                    w_state_nxt   = ST_FCS;
                end
            end
            ST_PAD: begin
                w_en        = 1'b1;
                w_crc_en    = 1'b1;
                w_count_nxt = w_count_inc;
                w_overrun   = w_rise;
                if (w_count_inc >= c_min) begin
                    w_fcs_idx_nxt = 2'd0;
                    w_state_nxt   = ST_FCS;
                end
            end
            ST_FCS: begin
                w_byte        = w_fcs_byte;
                w_en          = 1'b1;
                w_overrun     = w_rise;
                w_fcs_idx_nxt = r_fcs_idx + 2'd1;
                if (r_fcs_idx == 2'd3) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!in_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        r_in_valid_prev <= in_valid;
        if (reset) begin
            r_state         <= ST_IDLE;
            r_count         <= 11'd0;
            r_fcs_idx       <= 2'd0;
            r_too_long_seen <= 1'b0;
            out_data        <= 8'h00;
            out_enable      <= 1'b0;
            overrun         <= 1'b0;
            too_long        <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_count         <= w_count_nxt;
            r_fcs_idx       <= w_fcs_idx_nxt;
            r_too_long_seen <= w_too_long_seen_nxt;
            out_data        <= w_byte;
            out_enable      <= w_en;
            overrun         <= w_overrun;
            too_long        <= w_too_long;
        end
    end

endmodule

`default_nettype wire
